// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-miniRISC control unit and anything that drives or checks the datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kgp_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'd0,
        OP_ADDI  = 6'd1,
        OP_COMPI = 6'd2,
        OP_LW    = 6'd3,
        OP_SW    = 6'd4,
        OP_BR    = 6'd5,
        OP_BLTZ  = 6'd6,
        OP_BZ    = 6'd7,
        OP_BNZ   = 6'd8,
        OP_B     = 6'd9,
        OP_BL    = 6'd10,
        OP_BCY   = 6'd11,
        OP_BNCY  = 6'd12
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_COMP  = 4'd1,
        ALU_AND   = 4'd2,
        ALU_XOR   = 4'd3,
        ALU_SHLL  = 4'd4,
        ALU_SHRL  = 4'd5,
        ALU_SHLLV = 4'd6,
        ALU_SHRLV = 4'd7,
        ALU_SHRA  = 4'd8,
        ALU_SHRAV = 4'd9,
        ALU_DIFF  = 4'd10
    } alu_op_t;

    // Largest R-type func value that maps onto a real ALU operation.
    localparam logic [5:0] FUNC_MAX = 6'd10;

    typedef enum logic [4:0] {
        BR_NONE = 5'd0,
        BR_B    = 5'd1,
        BR_BL   = 5'd2,
        BR_BCY  = 5'd3,
        BR_BNCY = 5'd4,
        BR_BR   = 5'd5,
        BR_BLTZ = 5'd6,
        BR_BZ   = 5'd7,
        BR_BNZ  = 5'd8
    } br_op_t;

    typedef enum logic [1:0] {
        RW_NONE = 2'b00,
        RW_RD   = 2'b01,
        RW_LINK = 2'b10
    } reg_write_t;

    typedef enum logic [1:0] {
        RWM_PC4 = 2'b00,
        RWM_MEM = 2'b01,
        RWM_ALU = 2'b10
    } rw_mux_t;

    typedef enum logic {
        IMM_SEXT = 1'b0,
        IMM_ZEXT = 1'b1
    } imm_ext_t;

    typedef enum logic {
        ALU_B_REG = 1'b0,
        ALU_B_IMM = 1'b1
    } alu_src_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_LOAD    = 3'd1,
        CLS_STORE   = 3'd2,
        CLS_BRANCH  = 3'd3,
        CLS_ILLEGAL = 3'd4
    } instr_cls_t;

    // Everything the FSM needs to know about one instruction.
    typedef struct packed {
        instr_cls_t  cls;
        logic [3:0]  alu_op;
        logic        alu_mux;
        logic        imm_mux;
        logic [4:0]  br_op;
        logic        link;
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode/func classifier producing the per-instruction control word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module ctrl_decoder
    import kgp_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    output ctrl_word_t  cw
);

    // Unknown opcodes and out-of-range R-type funcs fall through as CLS_ILLEGAL with an all-zero word.
    always_comb begin
        cw         = '0;
        cw.cls     = CLS_ILLEGAL;
        cw.alu_op  = ALU_ADD;
        cw.alu_mux = ALU_B_REG;
        cw.imm_mux = IMM_SEXT;
        cw.br_op   = BR_NONE;
        cw.link    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (func <= FUNC_MAX) begin
                    cw.cls    = CLS_ALU;
                    cw.alu_op = func[3:0];
                end
            end
            OP_ADDI: begin
                cw.cls     = CLS_ALU;
                cw.alu_op  = ALU_ADD;
                cw.alu_mux = ALU_B_IMM;
            end
            OP_COMPI: begin
                cw.cls     = CLS_ALU;
                cw.alu_op  = ALU_COMP;
                cw.alu_mux = ALU_B_IMM;
            end
            OP_LW: begin
                cw.cls     = CLS_LOAD;
                cw.alu_mux = ALU_B_IMM;
            end
            OP_SW: begin
                cw.cls     = CLS_STORE;
                cw.alu_mux = ALU_B_IMM;
            end
            OP_BR:   begin cw.cls = CLS_BRANCH; cw.br_op = BR_BR;   end
            OP_BLTZ: begin cw.cls = CLS_BRANCH; cw.br_op = BR_BLTZ; end
            OP_BZ:   begin cw.cls = CLS_BRANCH; cw.br_op = BR_BZ;   end
            OP_BNZ:  begin cw.cls = CLS_BRANCH; cw.br_op = BR_BNZ;  end
            OP_B:    begin cw.cls = CLS_BRANCH; cw.br_op = BR_B;    end
            OP_BL: begin
                cw.cls   = CLS_BRANCH;
                cw.br_op = BR_BL;
                cw.link  = 1'b1;
            end
            OP_BCY:  begin cw.cls = CLS_BRANCH; cw.br_op = BR_BCY;  end
            OP_BNCY: begin cw.cls = CLS_BRANCH; cw.br_op = BR_BNCY; end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control FSM for KGP-miniRISC; sequences fetch/decode/exec/mem/wb and drives data_path controls.
// Latency: branch 3, R-type/imm 4, sw 4, lw 5 cycles per instruction; all outputs registered.
// Backpressure: none; en is sampled only in IDLE. CTRL_ILLEGAL_TRAP_EN selects trap-to-HALT on illegal instructions.
module control_unit
    import kgp_ctrl_pkg::*;
#(
    parameter int ILLEGAL_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [5:0]           opcode,
    input  logic [5:0]           func,
    output logic                 pc_en,
    output logic                 ir_en,
    output logic [1:0]           reg_write,
    output logic                 imm_mux_ctrl,
    output logic                 alu_mux_ctrl,
    output logic [3:0]           alu_op,
    output logic                 dmem_enable,
    output logic                 dmem_write_enable,
    output logic [1:0]           reg_write_mux_ctrl,
    output logic [4:0]           br_op,
    output logic [2:0]           state_out,
    output logic [ILLEGAL_W-1:0] illegal
);

    state_t     state;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic [5:0] dec_op;
    logic [5:0] dec_fn;
    ctrl_word_t cw;

    // The live opcode is only looked at on the DECODE->EXEC edge, where it is also captured;
    // every later state decodes the captured copy, so input changes after DECODE are inert.
    assign dec_op = (state == ST_DECODE) ? opcode : op_q;
    assign dec_fn = (state == ST_DECODE) ? func   : fn_q;

    ctrl_decoder u_dec (
        .opcode (dec_op),
        .func   (dec_fn),
        .cw     (cw)
    );

    assign state_out = state;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;

    // Sticky illegal flag, raised together with the move into HALT; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal <= '0;
        end else if (state == ST_DECODE && cw.cls == CLS_ILLEGAL) begin
            illegal <= ILLEGAL_W'(1);
        end
    end
`else
    localparam bit TRAP_EN = 1'b0;

    assign illegal = '0;
`endif

    // State sequencing plus registered outputs: each transition loads the outputs for the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE;
            op_q               <= '0;
            fn_q               <= '0;
            pc_en              <= 1'b0;
            ir_en              <= 1'b0;
            reg_write          <= RW_NONE;
            reg_write_mux_ctrl <= RWM_PC4;
            dmem_enable        <= 1'b0;
            dmem_write_enable  <= 1'b0;
            br_op              <= BR_NONE;
            alu_op             <= ALU_ADD;
            alu_mux_ctrl       <= ALU_B_REG;
            imm_mux_ctrl       <= IMM_SEXT;
        end else begin
            pc_en              <= 1'b0;
            ir_en              <= 1'b0;
            reg_write          <= RW_NONE;
            reg_write_mux_ctrl <= RWM_PC4;
            dmem_enable        <= 1'b0;
            dmem_write_enable  <= 1'b0;
            br_op              <= BR_NONE;
            alu_op             <= ALU_ADD;
            alu_mux_ctrl       <= ALU_B_REG;
            imm_mux_ctrl       <= IMM_SEXT;
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state <= ST_FETCH;
                        ir_en <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    op_q <= opcode;
                    fn_q <= func;
                    if (TRAP_EN && cw.cls == CLS_ILLEGAL) begin
                        state <= ST_HALT;
                    end else begin
                        state        <= ST_EXEC;
                        alu_op       <= cw.alu_op;
                        alu_mux_ctrl <= cw.alu_mux;
                        imm_mux_ctrl <= cw.imm_mux;
                        // Branches resolve here; an untrapped illegal instruction retires as a NOP here too.
                        if (cw.cls == CLS_BRANCH || cw.cls == CLS_ILLEGAL) begin
                            pc_en <= 1'b1;
                            br_op <= cw.br_op;
                        end
                        if (cw.link) begin
                            reg_write          <= RW_LINK;
                            reg_write_mux_ctrl <= RWM_PC4;
                        end
                    end
                end
                ST_EXEC: begin
                    case (cw.cls)
                        CLS_LOAD, CLS_STORE: begin
                            state        <= ST_MEM;
                            dmem_enable  <= 1'b1;
                            alu_op       <= cw.alu_op;
                            alu_mux_ctrl <= cw.alu_mux;
                            imm_mux_ctrl <= cw.imm_mux;
                            if (cw.cls == CLS_STORE) begin
                                dmem_write_enable <= 1'b1;
                                pc_en             <= 1'b1;
                            end
                        end
                        CLS_ALU: begin
                            state              <= ST_WB;
                            reg_write          <= RW_RD;
                            reg_write_mux_ctrl <= RWM_ALU;
                            pc_en              <= 1'b1;
                            alu_op             <= cw.alu_op;
                            alu_mux_ctrl       <= cw.alu_mux;
                            imm_mux_ctrl       <= cw.imm_mux;
                        end
                        default: begin
                            state <= ST_FETCH;
                            ir_en <= 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (cw.cls == CLS_LOAD) begin
                        state              <= ST_WB;
                        reg_write          <= RW_RD;
                        reg_write_mux_ctrl <= RWM_MEM;
                        pc_en              <= 1'b1;
                        alu_op             <= cw.alu_op;
                        alu_mux_ctrl       <= cw.alu_mux;
                        imm_mux_ctrl       <= cw.imm_mux;
                    end else begin
                        state <= ST_FETCH;
                        ir_en <= 1'b1;
                    end
                end
                ST_WB: begin
                    state <= ST_FETCH;
                    ir_en <= 1'b1;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized self-checking bench for control_unit against a per-instruction cycle-table model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_control_unit;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       pc_en;
    logic       ir_en;
    logic [1:0] reg_write;
    logic       imm_mux_ctrl;
    logic       alu_mux_ctrl;
    logic [3:0] alu_op;
    logic       dmem_enable;
    logic       dmem_write_enable;
    logic [1:0] reg_write_mux_ctrl;
    logic [4:0] br_op;
    logic [2:0] state_out;
    logic [0:0] illegal;

    control_unit dut (
        .clk                (clk),
        .rst                (rst),
        .en                 (en),
        .opcode             (opcode),
        .func               (func),
        .pc_en              (pc_en),
        .ir_en              (ir_en),
        .reg_write          (reg_write),
        .imm_mux_ctrl       (imm_mux_ctrl),
        .alu_mux_ctrl       (alu_mux_ctrl),
        .alu_op             (alu_op),
        .dmem_enable        (dmem_enable),
        .dmem_write_enable  (dmem_write_enable),
        .reg_write_mux_ctrl (reg_write_mux_ctrl),
        .br_op              (br_op),
        .state_out          (state_out),
        .illegal            (illegal)
    );

    always #5 clk = ~clk;

    // One cycle's worth of expected outputs.
    typedef struct packed {
        logic [2:0] st;
        logic       pc_en;
        logic       ir_en;
        logic [1:0] rw;
        logic       imm;
        logic       amux;
        logic [3:0] aop;
        logic       dme;
        logic       dmwe;
        logic [1:0] rwm;
        logic [4:0] br;
        logic       ill;
    } exp_t;

    exp_t act_v;
    assign act_v = {state_out, pc_en, ir_en, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
                    dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op, illegal};

    exp_t exp_q[$];
    exp_t last_recs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, act, want);
        end
    endtask

    function automatic exp_t blank(input int st);
        exp_t r;
        r    = '0;
        r.st = 3'(st);
        return r;
    endfunction

    // Cycle table for one instruction, starting at its FETCH cycle.
    function automatic void model(input int op, input int fn);
        exp_t r;
        bit   legal;
        int   aop;
        bit   amux;
        last_recs.delete();
        legal = (op <= 12) && !(op == 0 && fn > 10);
        r = blank(1); r.ir_en = 1'b1; last_recs.push_back(r);
        last_recs.push_back(blank(2));
        if (!legal) begin
            if (TRAP) begin
                for (int i = 0; i < 50; i++) begin
                    r = blank(6); r.ill = 1'b1; last_recs.push_back(r);
                end
            end else begin
                r = blank(3); r.pc_en = 1'b1; last_recs.push_back(r);
            end
            return;
        end
        if (op >= 5) begin
            r = blank(3);
            r.pc_en = 1'b1;
            r.br = 5'((op <= 8) ? op : op - 8);
            if (op == 10) begin
                r.rw  = 2'd2;
                r.rwm = 2'd0;
            end
            last_recs.push_back(r);
            return;
        end
        aop  = (op == 0) ? fn : ((op == 2) ? 1 : 0);
        amux = (op != 0);
        r = blank(3); r.aop = 4'(aop); r.amux = amux; last_recs.push_back(r);
        if (op == 3 || op == 4) begin
            r = blank(4); r.aop = 4'(aop); r.amux = amux; r.dme = 1'b1;
            if (op == 4) begin
                r.dmwe  = 1'b1;
                r.pc_en = 1'b1;
                last_recs.push_back(r);
                return;
            end
            last_recs.push_back(r);
        end
        r = blank(5); r.aop = 4'(aop); r.amux = amux;
        r.rw = 2'd1; r.rwm = (op == 3) ? 2'd1 : 2'd2; r.pc_en = 1'b1;
        last_recs.push_back(r);
    endfunction

    // Compare process: one expected record per cycle whenever the model has one queued.
    initial begin : cmp
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (act_v !== e) begin
                    errors++;
                    $display("FAIL cycle_outputs cyc=%0d got=%h want=%h (state got %0d want %0d)",
                             cyc, act_v, e, state_out, e.st);
                end
            end
        end
    end

    // Called at posedge+1 one cycle before the instruction's FETCH edge.
    task automatic run_instr(input int op, input int fn, input bit start);
        int n;
        model(op, fn);
        n      = last_recs.size();
        opcode = 6'(op);
        func   = 6'(fn);
        if (start) begin
            en = 1'b1;
            exp_q.push_back(blank(0));
        end
        foreach (last_recs[i]) exp_q.push_back(last_recs[i]);
        repeat (3) @(posedge clk);
        #1;
        opcode = 6'($urandom);
        func   = 6'($urandom);
        en     = 1'($urandom);
        if (n > 3) begin
            repeat (n - 3) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        for (int i = 0; i < n; i++) exp_q.push_back(blank(0));
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int op;
        int fn;
        rst    = 1'b0;
        en     = 1'b0;
        opcode = '0;
        func   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'(act_v), 0);
        rst = 1'b1;
        idle(2);

        // Directed instructions with model pins.
        run_instr(0, 3, 1'b1);
        chk("xor_len", last_recs.size(), 4);
        chk("xor_wb_state", int'(last_recs[3].st), 5);
        chk("xor_wb_aop", int'(last_recs[3].aop), 3);
        chk("xor_wb_rw", int'(last_recs[3].rw), 1);
        chk("xor_wb_rwm", int'(last_recs[3].rwm), 2);
        run_instr(1, 0, 1'b0);
        chk("addi_len", last_recs.size(), 4);
        chk("addi_exec_amux", int'(last_recs[2].amux), 1);
        run_instr(3, 0, 1'b0);
        chk("lw_len", last_recs.size(), 5);
        chk("lw_mem_dme", int'(last_recs[3].dme), 1);
        chk("lw_wb_rwm", int'(last_recs[4].rwm), 1);
        run_instr(4, 0, 1'b0);
        chk("sw_len", last_recs.size(), 4);
        chk("sw_mem_dmwe", int'(last_recs[3].dmwe), 1);
        chk("sw_mem_rw", int'(last_recs[3].rw), 0);
        run_instr(9, 0, 1'b0);
        chk("b_len", last_recs.size(), 3);
        chk("b_br", int'(last_recs[2].br), 1);
        run_instr(10, 0, 1'b0);
        chk("bl_len", last_recs.size(), 3);
        chk("bl_br", int'(last_recs[2].br), 2);
        chk("bl_rw", int'(last_recs[2].rw), 2);

        // Random instruction stream; illegal encodings only where they do not halt the core.
        for (int i = 0; i < 150; i++) begin
            op = int'($urandom_range(0, 12));
            fn = int'($urandom_range(0, 10));
            if (!TRAP && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    op = int'($urandom_range(13, 63));
                end else begin
                    op = 0;
                    fn = int'($urandom_range(11, 63));
                end
            end
            run_instr(op, fn, 1'b0);
        end

        // sw interrupted by reset during its MEM cycle.
        model(4, 0);
        opcode = 6'd4;
        func   = 6'd0;
        foreach (last_recs[i]) exp_q.push_back(last_recs[i]);
        repeat (4) @(posedge clk);
        #7;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        chk("rst_async_outputs", int'(act_v), 0);
        chk("rst_async_dmwe", int'(dmem_write_enable), 0);
        chk("rst_queue_drained", exp_q.size(), 0);
        exp_q.push_back(blank(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // Illegal opcode 20: HALT in the trap build, NOP otherwise.
        run_instr(20, 0, 1'b1);
        chk("ill_len", last_recs.size(), TRAP ? 52 : 3);
        if (!TRAP) run_instr(9, 0, 1'b0);

        for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        chk("final_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
